// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: funct3 load/store codes
// and the responder FSM state encoding.
package dmem_responder_pkg;

    // Load funct3 codes
    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] FNC_SB  = 3'b000;
    localparam logic [2:0] FNC_SH  = 3'b001;
    localparam logic [2:0] FNC_SW  = 3'b010;

    // Responder FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } dmem_state_e;

endpackage

// File: rtl/dmem_format.sv
// Combinational data formatting for the memory responder: store byte-lane
// replication and write mask, load lane extraction with sign/zero
// extension, and the misaligned / illegal-funct3 check.
module dmem_format
    import dmem_responder_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_wmask_o,
    output logic [31:0] ld_data_o,
    output logic        err_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign ld_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // Decode funct3 per direction; unknown codes and misaligned sizes flag an error
    always_comb begin
        st_wdata_o = '0;
        st_wmask_o = '0;
        ld_data_o  = '0;
        err_o      = 1'b0;
        if (we_i) begin
            case (funct3_i)
                FNC_SB: begin
                    st_wdata_o = {4{wdata_i[7:0]}};
                    st_wmask_o = 4'b0001 << addr_lo_i;
                end
                FNC_SH: begin
                    st_wdata_o = {2{wdata_i[15:0]}};
                    st_wmask_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    err_o      = addr_lo_i[0];
                end
                FNC_SW: begin
                    st_wdata_o = wdata_i;
                    st_wmask_o = 4'b1111;
                    err_o      = (addr_lo_i != 2'b00);
                end
                default: err_o = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                FNC_LB:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
                FNC_LBU: ld_data_o = {24'b0, ld_byte};
                FNC_LH: begin
                    ld_data_o = {{16{ld_half[15]}}, ld_half};
                    err_o     = addr_lo_i[0];
                end
                FNC_LHU: begin
                    ld_data_o = {16'b0, ld_half};
                    err_o     = addr_lo_i[0];
                end
                FNC_LW: begin
                    ld_data_o = rdata_i;
                    err_o     = (addr_lo_i != 2'b00);
                end
                default: err_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one X-stage load/store at a time, issues a
// single word-addressed memory transaction, waits (with timeout) for load
// data, and returns a one-cycle formatted response while stalling the pipe.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int MEM_LAT_MAX = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int               CNT_W    = $clog2(MEM_LAT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT_MAX - 1);

    dmem_state_e      state_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             we_q;
    logic [2:0]       funct3_q;
    logic [1:0]       addr_lo_q;

    logic             resp_valid_q;
    logic             resp_err_q;
    logic [31:0]      resp_rdata_q;
    logic             mem_req_valid_q;
    logic             mem_we_q;
    logic [29:0]      mem_addr_q;
    logic [31:0]      mem_wdata_q;
    logic [3:0]       mem_wmask_q;

    logic             in_idle;
    logic             busy;
    logic             accept;

    logic             fmt_we;
    logic [2:0]       fmt_funct3;
    logic [1:0]       fmt_addr_lo;
    logic [31:0]      fmt_st_wdata;
    logic [3:0]       fmt_st_wmask;
    logic [31:0]      fmt_ld_data;
    logic             fmt_err;

    assign in_idle = (state_q == ST_IDLE);
    assign busy    = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign accept  = in_idle && req_valid && !flush;

    // The formatter sees the live request while idle (error check, store
    // alignment) and the latched request afterwards (load extraction).
    assign fmt_we      = in_idle ? req_we          : we_q;
    assign fmt_funct3  = in_idle ? req_funct3      : funct3_q;
    assign fmt_addr_lo = in_idle ? req_addr[1:0]   : addr_lo_q;

    dmem_format u_format (
        .we_i       (fmt_we),
        .funct3_i   (fmt_funct3),
        .addr_lo_i  (fmt_addr_lo),
        .wdata_i    (req_wdata),
        .rdata_i    (mem_resp_data),
        .st_wdata_o (fmt_st_wdata),
        .st_wmask_o (fmt_st_wmask),
        .ld_data_o  (fmt_ld_data),
        .err_o      (fmt_err)
    );

    // Stall must rise in the accept cycle itself, so it is the only
    // combinational output; it is forced low while reset is held.
    assign stall         = reset_n && (busy || accept);
    assign resp_valid    = resp_valid_q;
    assign resp_err      = resp_err_q;
    assign resp_rdata    = resp_rdata_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wmask     = mem_wmask_q;

    // Responder FSM with latency counter and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            wait_cnt_q      <= '0;
            we_q            <= 1'b0;
            funct3_q        <= 3'b000;
            addr_lo_q       <= 2'b00;
            resp_valid_q    <= 1'b0;
            resp_err_q      <= 1'b0;
            resp_rdata_q    <= '0;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        we_q       <= req_we;
                        funct3_q   <= req_funct3;
                        addr_lo_q  <= req_addr[1:0];
                        wait_cnt_q <= '0;
                        if (fmt_err) begin
                            // Rejected ops never touch memory
                            state_q      <= ST_DONE;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q         <= ST_ISSUE;
                            mem_req_valid_q <= 1'b1;
                            mem_we_q        <= req_we;
                            mem_addr_q      <= req_addr[31:2];
                            mem_wdata_q     <= req_we ? fmt_st_wdata : 32'h0;
                            mem_wmask_q     <= req_we ? fmt_st_wmask : 4'h0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        mem_we_q        <= 1'b0;
                        mem_addr_q      <= '0;
                        mem_wdata_q     <= '0;
                        mem_wmask_q     <= '0;
                        if (we_q) begin
                            state_q      <= ST_DONE;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b0;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        state_q      <= ST_DONE;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= fmt_ld_data;
                    end else if (wait_cnt_q == CNT_LAST) begin
                        state_q      <= ST_DONE;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Response lasts one cycle; a request seen now waits for IDLE
                    state_q      <= ST_IDLE;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    wait_cnt_q   <= '0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: MEM_LAT_MAX, 16, cycles dmem_resp_valid may lag acceptance before timeout error.
REQ-002 Ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Ports: reset_n  in  1  asynchronous, active-low reset.
REQ-004 Ports: req_valid  in  1  X-stage memory op present (load or store).
REQ-005 Ports: req_we  in  1  1=store, 0=load.
REQ-006 Ports: req_funct3  in  3  LB/LH/LW/LBU/LHU or SB/SH/SW code.
REQ-007 Ports: req_addr  in  32  byte address; req_wdata  in  32  store data (low bytes significant).
REQ-008 Ports: flush  in  1  branch/jump flush; disqualifies req_valid this cycle.
REQ-009 Ports: stall  out  1  freeze pipeline; resp_valid  out  1  op complete; resp_rdata  out  32  formatted load data; resp_err  out  1  misaligned/illegal/timeout.
REQ-010 Ports: mem_req_valid  out  1; mem_req_ready  in  1; mem_we  out  1; mem_addr  out  30  word address; mem_wdata  out  32; mem_wmask  out  4.
REQ-011 Ports: mem_resp_valid  in  1; mem_resp_data  in  32  full read word.

Function
REQ-012 FSM states IDLE, ISSUE, WAIT, DONE; encoding 2 bits.
REQ-013 IDLE: accept when req_valid && !flush; latch we, funct3, addr, wdata; stall=1 combinationally in accept cycle.
REQ-014 Accept, aligned and legal funct3 -> ISSUE; misaligned (H: addr[0]=1, W: addr[1:0]!=0) or illegal funct3 -> DONE with resp_err=1, no memory transaction.
REQ-015 ISSUE: mem_req_valid=1, outputs stable until mem_req_ready; store & ready -> DONE; load & ready -> WAIT.
REQ-016 WAIT: mem_resp_valid -> capture formatted data, -> DONE; mem_resp_valid earliest one cycle after handshake.
REQ-017 WAIT timeout counter: MEM_LAT_MAX cycles without mem_resp_valid -> DONE, resp_err=1, resp_rdata=0.
REQ-018 DONE: resp_valid=1 for exactly one cycle, stall=0, -> IDLE; new request in DONE cycle not accepted (taken next cycle in IDLE).
REQ-019 stall=1 in ISSUE and WAIT; stall=0 in IDLE (except accept cycle) and DONE.
REQ-020 Store align: SB wdata byte replicated x4, mask=1<<addr[1:0]; SH half replicated x2, mask=0011/1100 by addr[1]; SW mask=1111.
REQ-021 Load format: byte/half selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend; stores return resp_rdata=0.
REQ-022 Minimum latency, ready=1: store resp_valid at T+2, load at T+3 (T=accept cycle).
REQ-023 flush while not IDLE ignored: issued transaction completes normally.
REQ-024 mem_resp_valid outside WAIT ignored (stale response after reset dropped).
REQ-025 mem_addr = latched addr[31:2]; mem_req_valid never asserted outside ISSUE.

Reset
REQ-026 reset_n low: state=IDLE, timeout counter=0, all outputs 0 (stall, resp_valid, resp_err, resp_rdata, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask) regardless of operation in flight.
REQ-027 First acceptance possible in first clk edge after reset_n deasserts.

Structure
REQ-028 funct3 load/store codes and FSM state encoding reside in the shared opcode/constants header with existing FNC_/OPC_ definitions.
REQ-029 Combinational sub-module dmem_format performs store alignment/mask and load extraction/extension; FSM and counter in dmem_responder.

Verification
REQ-030 SW addr 0x100 data 0xDEADBEEF, ready=1 -> one handshake, mem_addr=0x40, mask=1111, resp_valid T+2, stall high T, T+1.
REQ-031 LB addr 0x103, memory word 0x80FF_0000 -> resp_rdata=0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF80FF.
REQ-032 LW addr 0x102 -> no mem_req_valid, resp_err=1, resp_valid at T+1.
REQ-033 req_valid with flush=1 -> no acceptance, stall=0; flush during WAIT -> load completes with correct data.
REQ-034 mem_req_ready held low 5 cycles -> mem_req_valid/addr/wmask stable throughout; no response for MEM_LAT_MAX=16 -> resp_err=1.
REQ-035 reset_n pulsed low in WAIT -> IDLE, outputs 0; late mem_resp_valid ignored; next SB addr 0x5 -> mask 0010.
